// File: rtl/vmu_mem_responder.sv
// Memory-side responder for VMU load/store requests: zero-fills on reset, then grants every cycle.
// Optional macro VMU_MEM_RESP_REG_EN adds a registered output stage (latency LOAD_LATENCY+1).
module vmu_mem_responder #(
  parameter int REQ_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int VECTOR_LANES   = 8,
  parameter int MEM_WORDS      = 256,
  parameter int LOAD_LATENCY   = 2,
  localparam int TW            = $clog2(VECTOR_LANES) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  input  logic                      req_is_store_i,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [TW-1:0]             req_ticket_i,
  input  logic [REQ_DATA_WIDTH-1:0] req_data_i,
  output logic                      grant_o,
  output logic                      resp_valid_o,
  output logic [TW-1:0]             resp_ticket_o,
  output logic [REQ_DATA_WIDTH-1:0] resp_data_o,
  output logic                      init_done_o,
  output logic                      idle_o
);

  localparam int AW  = $clog2(MEM_WORDS);
  localparam int OFS = $clog2(REQ_DATA_WIDTH / 8);
`ifdef VMU_MEM_RESP_REG_EN
  localparam int DEPTH = LOAD_LATENCY + 1;
`else
  localparam int DEPTH = LOAD_LATENCY;
`endif
  localparam int CW = $clog2(DEPTH + 1) + 1;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                    state_q, state_d;
  logic [AW-1:0]             ptr_q, ptr_d;
  logic [AW-1:0]             req_idx;
  logic                      load_acc;
  logic                      mem_we;
  logic [AW-1:0]             mem_waddr;
  logic [REQ_DATA_WIDTH-1:0] mem_wdata;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      unused_addr;

  logic [REQ_DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [LOAD_LATENCY-1:0]   vld_q;
  logic [TW-1:0]             tkt_q [LOAD_LATENCY];
  logic [REQ_DATA_WIDTH-1:0] dat_q [LOAD_LATENCY];

  // Upper and sub-word address bits are intentionally dropped: accesses wrap.
  assign req_idx     = req_addr_i[OFS +: AW];
  assign unused_addr = ^req_addr_i;
  assign load_acc    = req_valid_i & grant_o & ~req_is_store_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(MEM_WORDS - 1)) state_d = ST_READY;
      end
      default: ;
    endcase
  end

  always_comb begin
    grant_o     = 1'b0;
    init_done_o = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = req_idx;
    mem_wdata   = req_data_i;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
      end
      ST_READY: begin
        grant_o     = 1'b1;
        init_done_o = 1'b1;
        mem_we      = req_valid_i & req_is_store_i;
      end
      default: ;
    endcase
  end

  // Load data is sampled at acceptance, so younger stores cannot disturb it.
  // Stage data only advances with a valid, which gives the hold-last-value output.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (rst_i) begin
      vld_q <= '0;
      for (int k = 0; k < LOAD_LATENCY; k++) begin
        tkt_q[k] <= '0;
        dat_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= load_acc;
      if (load_acc) begin
        tkt_q[0] <= req_ticket_i;
        dat_q[0] <= mem_q[req_idx];
      end
      for (int k = 1; k < LOAD_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          tkt_q[k] <= tkt_q[k-1];
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

`ifdef VMU_MEM_RESP_REG_EN
  logic                      out_vld_q;
  logic [TW-1:0]             out_tkt_q;
  logic [REQ_DATA_WIDTH-1:0] out_dat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_q <= 1'b0;
      out_tkt_q <= '0;
      out_dat_q <= '0;
    end else begin
      out_vld_q <= vld_q[LOAD_LATENCY-1];
      if (vld_q[LOAD_LATENCY-1]) begin
        out_tkt_q <= tkt_q[LOAD_LATENCY-1];
        out_dat_q <= dat_q[LOAD_LATENCY-1];
      end
    end
  end

  assign resp_valid_o  = out_vld_q;
  assign resp_ticket_o = out_tkt_q;
  assign resp_data_o   = out_dat_q;
`else
  assign resp_valid_o  = vld_q[LOAD_LATENCY-1];
  assign resp_ticket_o = tkt_q[LOAD_LATENCY-1];
  assign resp_data_o   = dat_q[LOAD_LATENCY-1];
`endif

  always_comb begin
    cnt_d = cnt_q;
    case ({load_acc, resp_valid_o})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign idle_o = init_done_o & (cnt_q == '0);

endmodule

// File: doc/vmu_mem_responder.md
# vmu_mem_responder

Memory-side responder for the vector memory unit request/response protocol. It sits between the VMU and a local vector data memory. It grants load and store requests, performs each store into a word-addressed memory, and returns load data tagged with the request ticket after a fixed, parameterised latency. A post-reset initialisation FSM zero-fills the memory before the first grant.

## Interface
- REQ_DATA_WIDTH, 32, data width of one request/response word (multiple of 8)
- ADDR_WIDTH, 32, request byte-address width
- VECTOR_LANES, 8, sets ticket width TW = $clog2(VECTOR_LANES)+1
- MEM_WORDS, 256, memory depth in words (power of two, ≥2)
- LOAD_LATENCY, 2, cycles from load acceptance to response (≥1)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  request valid (mem_req_valid_o of VMU)
- req_is_store_i  in  1  1 = store (microop opcode_vstore_c), 0 = load (opcode_vload_c)
- req_addr_i  in  ADDR_WIDTH  byte address
- req_ticket_i  in  TW  load ticket, returned unchanged
- req_data_i  in  REQ_DATA_WIDTH  store data
- grant_o  out  1  request accepted this cycle when req_valid_i & grant_o (drives cache_ready_i)
- resp_valid_o  out  1  load response valid for one cycle (no backpressure)
- resp_ticket_o  out  TW  ticket of the response
- resp_data_o  out  REQ_DATA_WIDTH  load data
- init_done_o  out  1  memory zero-fill complete
- idle_o  out  1  no load in flight and init done

## Operation
- Word index = req_addr_i[OFS +: $clog2(MEM_WORDS)], with OFS = $clog2(REQ_DATA_WIDTH/8). Upper address bits are ignored, so addresses wrap modulo the memory size. Low OFS bits are ignored (aligned access only).
- FSM states are INIT and READY.
  - Reset enters INIT with init pointer = 0.
  - INIT writes zero to word[ptr] and increments ptr each cycle. After writing word MEM_WORDS-1 it moves to READY; this takes exactly MEM_WORDS cycles.
  - READY: grant_o = 1 every cycle. grant_o is 0 in INIT, and requests in INIT are ignored.
- An accepted store writes req_data_i to the word at the acceptance edge and produces no response.
- An accepted load reads the word at the acceptance edge and enters a LOAD_LATENCY-deep valid/ticket/data pipeline.
  - Data is captured at acceptance, so a later store to the same word does not affect an earlier load.
  - A store accepted in an earlier cycle is visible to the load.
- One request is accepted per cycle. Back-to-back loads yield back-to-back responses in request order.
- An outstanding-load counter (width $clog2(LOAD_LATENCY+1)+1) increments on load accept and decrements on response. Both in the same cycle means no change.
  - idle_o = init_done_o & (count == 0).
- When resp_valid_o = 0, resp_ticket_o and resp_data_o hold their last value. They are 0 after reset.
- Reset mid-operation:
  - The pipeline and counter are flushed and in-flight responses are dropped.
  - The FSM returns to INIT and the memory is re-zeroed.

## Timing
- Reset values: grant_o=0, resp_valid_o=0, resp_ticket_o=0, resp_data_o=0, init_done_o=0, idle_o=0.
- After rst_i deasserts, grant_o rises after MEM_WORDS cycles. init_done_o rises in the same cycle.
- A load accepted at edge N produces resp_valid_o high in the cycle after edge N+LOAD_LATENCY-1. For the default LOAD_LATENCY=2, the response appears two cycles after the request cycle.
- grant_o is combinational from FSM state only. It never depends on req_valid_i.

## Configuration
- VMU_MEM_RESP_REG_EN: when defined, a registered output stage is added after the pipeline.
  - Response latency becomes LOAD_LATENCY+1.
  - The outstanding counter also covers the extra stage, and idle_o includes it.
  - When undefined, the latency is exactly LOAD_LATENCY and the outputs come directly from the last pipeline stage.

## Test plan
- Reset then idle, MEM_WORDS=256: grant_o=0 for 256 cycles, then grant_o=1, init_done_o=1, idle_o=1. A load of address 0x40 returns data 0x0000_0000.
- Store 0xDEAD_BEEF @0x10, then load @0x10 ticket 5 in the next cycle: resp_data_o=0xDEADBEEF, resp_ticket_o=5, exactly LOAD_LATENCY cycles after the load.
- Four back-to-back loads, tickets 1..4, from words holding 0x11, 0x22, 0x33, 0x44: four consecutive resp_valid_o cycles in order. idle_o=0 throughout and returns to 1 after the last response.
- Load @0x8 followed by a store of 0x5 @0x8 in the next cycle, where old data is 0x9: the response returns 0x9.
- Wrap-around: store 0xA5 @ byte address 4*MEM_WORDS+0xC, then load @0xC: the load returns 0xA5.
- Assert rst_i while two loads are in flight: no resp_valid_o pulse follows, grant_o=0 for MEM_WORDS cycles, and a previously stored word then reads 0.
